mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for the multiply class of operations.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for the divide class of operations.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port start, input, 1: operation request; sampled on the rising edge of clk.
REQ-006 Port mdu_op, input, 4: operation code. 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-10 are defined in REQ-026.
REQ-007 Port op1, input, 32: rs operand (dividend or multiplicand; source for mthi/mtlo).
REQ-008 Port op2, input, 32: rt operand (divisor or multiplier).
REQ-009 Port busy, output, 1: a multiply or divide is in progress.
REQ-010 Port hi, output, 32: HI register, driven directly from the register.
REQ-011 Port lo, output, 32: LO register, driven directly from the register.

Function
REQ-012 FSM states SHALL be IDLE, MUL and DIV. busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 An operation is accepted on an edge where start=1, busy=0, reset=0 and mdu_op is a valid code; otherwise start SHALL be ignored.
- start while busy=1: dropped, no queueing.
- Invalid or nop code: dropped.
REQ-014 On accepting mult/multu, the block SHALL capture op1/op2, load the counter with MULT_CYCLES and go to MUL.
REQ-015 On accepting div/divu, the block SHALL capture op1/op2, load the counter with DIV_CYCLES and go to DIV.
REQ-016 In MUL/DIV the counter SHALL decrement every cycle. On the edge where the counter equals 1:
- hi/lo are written;
- state returns to IDLE.
busy is therefore high for exactly N cycles after the accepting edge.
REQ-017 Operand changes after acceptance SHALL NOT affect the result.
REQ-018 hi/lo SHALL hold their old values while busy=1 and update only on the completion edge.
REQ-019 mult: {hi,lo} SHALL equal the signed 64-bit product. multu: {hi,lo} SHALL equal the unsigned 64-bit product.
REQ-020 div: lo SHALL be the quotient truncated toward zero and hi the remainder, with the remainder taking the sign of the dividend. divu: unsigned quotient in lo, unsigned remainder in hi.
REQ-021 Divide with op2=0 (div or divu) SHALL run the full DIV_CYCLES and leave hi and lo unchanged.
REQ-022 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 mthi/mtlo SHALL write op1 to hi/lo respectively on the accepting edge, with zero busy cycles. They are ignored while busy=1.
REQ-024 The first edge with busy=0 after a completion SHALL accept a new start (back-to-back operation).

Reset
REQ-025 reset=1 SHALL, on the next edge, force:
- state IDLE, busy=0, counter 0;
- hi=0, lo=0;
- any in-flight operation aborted without a result write.
reset has priority over start.

Configuration
REQ-026 With macro MDU_MADD_EN defined, codes 7 madd, 8 maddu, 9 msub, 10 msubu SHALL be valid multiply-class operations with MULT_CYCLES latency.
- madd: {hi,lo} += signed product.
- maddu: {hi,lo} += unsigned product.
- msub: {hi,lo} -= signed product.
- msubu: {hi,lo} -= unsigned product.
- The accumulate is modulo 2^64.
- The {hi,lo} value used is the one at the accepting edge.
REQ-027 Without MDU_MADD_EN, codes 7-10 SHALL be invalid: start is ignored, busy stays 0, and hi/lo are unchanged.

Verification
REQ-028 Signed multiply: mult with op1=0xFFFFFFFE (-2), op2=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 Signed divide: div with op1=-7, op2=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with op1=7, op2=2 -> lo=3, hi=1.
REQ-030 Divide by zero and overflow:
- mtlo 0x1234 and mthi 0x5678, then divu with op2=0 -> after 10 cycles hi=0x5678, lo=0x1234.
- div 0x80000000 by -1 -> lo=0x80000000, hi=0.
REQ-031 Start while busy: multu 0xFFFFFFFF*0xFFFFFFFF, then start=1 with div on cycle 2 of busy -> div ignored, busy falls after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Reset mid-operation: reset=1 on busy cycle 3 of a div -> next edge busy=0, hi=0, lo=0, and no later write.
REQ-033 Accumulate with MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu 1*1 -> hi=1, lo=0. Without the macro the same start -> busy stays 0 and hi/lo are unchanged.

Source files
------------

// File: rtl/mdu.sv
// mdu: HI/LO multiply/divide unit with fixed multi-cycle latency per operation class.
// Define MDU_MADD_EN to enable the accumulate ops madd/maddu/msub/msubu (codes 7-10).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int DATA_W     = 32;
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            op_p0;
    logic [DATA_W-1:0]     a_p0;
    logic [DATA_W-1:0]     b_p0;
    logic                  is_mul;
    logic                  is_div;
    logic                  wr_en;
    logic [2*DATA_W-1:0]   res;

    function automatic logic [2*DATA_W-1:0] mul64(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic sgn);
        logic signed [2*DATA_W-1:0] sa;
        logic signed [2*DATA_W-1:0] sb;
        sa = {{DATA_W{sgn & a[DATA_W-1]}}, a};
        sb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
        return sa * sb;
    endfunction

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 cleanly.
    function automatic logic [2*DATA_W-1:0] div64(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic sgn);
        logic              neg_a;
        logic              neg_b;
        logic [DATA_W-1:0] ua;
        logic [DATA_W-1:0] ub;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        neg_a = sgn & a[DATA_W-1];
        neg_b = sgn & b[DATA_W-1];
        ua = neg_a ? (~a + 1'b1) : a;
        ub = neg_b ? (~b + 1'b1) : b;
        q = ua / ub;
        r = ua % ub;
        if (neg_a ^ neg_b) q = ~q + 1'b1;
        if (neg_a) r = ~r + 1'b1;
        return {r, q};
    endfunction

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (mdu_op)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    // hi/lo cannot change while busy, so the live value is the accept-time accumulate base.
    always_comb begin
        res = {hi, lo};
        case (op_p0)
            OP_MULT:  res = mul64(a_p0, b_p0, 1'b1);
            OP_MULTU: res = mul64(a_p0, b_p0, 1'b0);
            OP_DIV:   res = div64(a_p0, b_p0, 1'b1);
            OP_DIVU:  res = div64(a_p0, b_p0, 1'b0);
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi, lo} + mul64(a_p0, b_p0, 1'b1);
            OP_MADDU: res = {hi, lo} + mul64(a_p0, b_p0, 1'b0);
            OP_MSUB:  res = {hi, lo} - mul64(a_p0, b_p0, 1'b1);
            OP_MSUBU: res = {hi, lo} - mul64(a_p0, b_p0, 1'b0);
`endif
            default: ;
        endcase
    end

    assign wr_en = !((state == DIV) && (b_p0 == '0));
    assign busy  = (state != IDLE);

    // Operand capture stage: held for the whole busy window.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start && (is_mul || is_div)) begin
            op_p0 <= mdu_op;
            a_p0  <= op1;
            b_p0  <= op2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                if (is_mul) begin
                    state <= MUL;
                    cnt   <= CNT_W'(MULT_CYCLES);
                end else if (is_div) begin
                    state <= DIV;
                    cnt   <= CNT_W'(DIV_CYCLES);
                end else if (mdu_op == OP_MTHI) begin
                    hi <= op1;
                end else if (mdu_op == OP_MTLO) begin
                    lo <= op1;
                end
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= IDLE;
                if (wr_en) begin
                    hi <= res[2*DATA_W-1:DATA_W];
                    lo <= res[DATA_W-1:0];
                end
            end
        end
    end
endmodule
